convolution_procesor_acc: RTL

- Sequential, parametrised successor to the two-input convolution adder.
- Accumulates a programmable-length stream of signed samples (convolution tap products) into one wide result.
- Uses a valid/ready input handshake and a done pulse.
- Sits between the product stage and the output buffer of the convolution IP core; replaces adder-tree chaining for variable kernel lengths.

---
 rtl/convolution_procesor_acc.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/convolution_procesor_acc.sv
// Sequential signed accumulator for convolution tap products with a valid/ready input handshake.
// Optional macro CONV_ACC_SATURATE_EN: clamp the accumulator on overflow instead of wrapping.
module convolution_procesor_acc #(
    parameter int DATA_WIDTH_IN = 16,
    parameter int DATA_WIDTH_O  = 22,
    parameter int LEN_WIDTH     = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [LEN_WIDTH-1:0]     len_i,
    input  logic [DATA_WIDTH_IN-1:0] data_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [DATA_WIDTH_O-1:0]  result_o,
    output logic                     done_o,
    output logic                     busy_o,
    output logic                     ovf_o
);

    if (DATA_WIDTH_O < DATA_WIDTH_IN) begin : g_width_check
        $error("DATA_WIDTH_O must be >= DATA_WIDTH_IN");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic [DATA_WIDTH_O-1:0]   acc_r;
    logic [DATA_WIDTH_O-1:0]   result_r;
    logic [LEN_WIDTH-1:0]      cnt_r;
    logic                      ovf_r;
    logic                      ready_r;
    logic                      busy_r;
    logic                      done_r;
    logic [DATA_WIDTH_O-1:0]   data_ext_s;
    logic [DATA_WIDTH_O-1:0]   sum_s;
    logic [DATA_WIDTH_O-1:0]   acc_next_s;
    logic                      ovf_add_s;
    logic                      accept_s;
    logic                      last_s;

    // Signed overflow: equal operand signs yielding a sum of the opposite sign.
    function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Sign-extended add with overflow detection and optional clamping.
    always_comb begin
        data_ext_s = DATA_WIDTH_O'($signed(data_i));
        sum_s      = acc_r + data_ext_s;
        ovf_add_s  = add_overflow(acc_r[DATA_WIDTH_O-1], data_ext_s[DATA_WIDTH_O-1],
                                  sum_s[DATA_WIDTH_O-1]);
`ifdef CONV_ACC_SATURATE_EN
        if (ovf_add_s) begin
            // Overflow direction follows the accumulator sign.
            acc_next_s = acc_r[DATA_WIDTH_O-1] ? {1'b1, {(DATA_WIDTH_O-1){1'b0}}}
                                               : {1'b0, {(DATA_WIDTH_O-1){1'b1}}};
        end else begin
            acc_next_s = sum_s;
        end
`else
        acc_next_s = sum_s;
`endif
    end

    assign accept_s = valid_i && ready_r;
    assign last_s   = (cnt_r == LEN_WIDTH'(1));

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_s = (len_i == {LEN_WIDTH{1'b0}}) ? DONE : ACC;
                end else begin
                    state_s = IDLE;
                end
            end
            ACC: begin
                if (accept_s && last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = ACC;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register with handshake/status flags registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == ACC);
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    // Accumulator, term counter, result and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r    <= {DATA_WIDTH_O{1'b0}};
            result_r <= {DATA_WIDTH_O{1'b0}};
            cnt_r    <= {LEN_WIDTH{1'b0}};
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        acc_r <= {DATA_WIDTH_O{1'b0}};
                        cnt_r <= len_i;
                        ovf_r <= 1'b0;
                        if (len_i == {LEN_WIDTH{1'b0}}) begin
                            result_r <= {DATA_WIDTH_O{1'b0}};
                        end
                    end
                end
                ACC: begin
                    if (accept_s) begin
                        acc_r <= acc_next_s;
                        cnt_r <= cnt_r - LEN_WIDTH'(1);
                        if (ovf_add_s) begin
                            ovf_r <= 1'b1;
                        end
                        if (last_s) begin
                            result_r <= acc_next_s;
                        end
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign ready_o  = ready_r;
    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign result_o = result_r;
    assign ovf_o    = ovf_r;

endmodule
